// File: rtl/if_id_pkg.sv
// Shared IF/ID definitions: queue sizing defaults and control state encoding.
// Used by the IF/ID buffer and its control block.
package if_id_pkg;

  localparam int IF_ID_SZ_DEF  = 8;
  localparam int IF_ID_IDX_DEF = 3;
  localparam int REDIRECT_DEF  = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } if_id_state_e;

  function automatic int wait_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/if_id_ctrl.sv
// IF/ID queue control: write/read strobes, occupancy and flush/redirect sequencing.
// Strobes drive all three buffer lanes (NPC, IR, valid) in lockstep.
module if_id_ctrl
  import if_id_pkg::*;
#(
  parameter int IF_ID_SZ     = IF_ID_SZ_DEF,
  parameter int IF_ID_IDX    = IF_ID_IDX_DEF,
  parameter int REDIRECT_LAT = REDIRECT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid1,
  input  logic             if_valid2,
  input  logic             id_accept1,
  input  logic             id_accept2,
  input  logic             flush,
  output logic             din1_en,
  output logic             din2_en,
  output logic             dout1_req,
  output logic             dout2_req,
  output logic             cb_clear,
  output logic             if_id_enable,
  output logic [IF_ID_IDX:0] count,
  output logic             out_valid1,
  output logic             out_valid2,
  output logic             fetch_stall,
  output logic             full,
  output logic             full_almost
);

  localparam int CW = IF_ID_IDX + 1;
  localparam int WW = wait_width(REDIRECT_LAT);

  localparam logic [IF_ID_IDX:0] SZ_C  = CW'(IF_ID_SZ);
  localparam logic [IF_ID_IDX:0] SZ_M1 = CW'(IF_ID_SZ - 1);
  localparam logic [IF_ID_IDX:0] SZ_M2 = CW'(IF_ID_SZ - 2);
  localparam logic [IF_ID_IDX:0] ONE_C = CW'(1);
  localparam logic [IF_ID_IDX:0] TWO_C = CW'(2);
  localparam logic [WW-1:0]      LAT_C = WW'(REDIRECT_LAT);
  localparam logic [WW-1:0]      W_ONE = WW'(1);

  if_id_state_e        state_q, state_d;
  logic [IF_ID_IDX:0]  count_q, count_d;
  logic [WW-1:0]       wait_q, wait_d;

  logic run_st;
  logic flush_st;
  logic wait_st;
  logic wr_ok;
  logic rd_ok;
  logic [IF_ID_IDX:0] cnt_nxt;

  always_comb begin
    run_st   = (state_q == ST_RUN);
    flush_st = (state_q == ST_FLUSH);
    wait_st  = (state_q == ST_WAIT);
    // Reset and flush both suppress every strobe in the cycle they are seen
    wr_ok    = reset && !flush && run_st;
    rd_ok    = reset && !flush && (run_st || wait_st);
  end

  always_comb begin
    din1_en   = wr_ok && if_valid1 && (count_q < SZ_C);
    din2_en   = din1_en && if_valid2 && (count_q <= SZ_M2);
    dout1_req = rd_ok && id_accept1 && (count_q >= ONE_C);
    dout2_req = dout1_req && id_accept2 && (count_q >= TWO_C);
    cnt_nxt   = count_q
              + CW'(din1_en) + CW'(din2_en)
              - CW'(dout1_req) - CW'(dout2_req);
  end

  always_comb begin
    cb_clear     = reset && flush_st;
    if_id_enable = run_st || wait_st;
    count        = count_q;
    out_valid1   = (count_q >= ONE_C);
    out_valid2   = (count_q >= TWO_C);
    full         = (count_q == SZ_C);
    full_almost  = (count_q >= SZ_M1);
    fetch_stall  = (count_q > SZ_M2) || !run_st;
  end

  always_comb begin
    state_d = state_q;
    count_d = cnt_nxt;
    wait_d  = wait_q;
    if (flush) begin
      state_d = ST_FLUSH;
      count_d = '0;
    end else begin
      case (state_q)
        ST_RUN: ;
        ST_FLUSH: begin
          count_d = '0;
          if (REDIRECT_LAT == 0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WAIT;
            wait_d  = LAT_C;
          end
        end
        ST_WAIT: begin
          wait_d = wait_q - W_ONE;
          if (wait_q <= W_ONE) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_FLUSH;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FLUSH;
      count_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed bench for if_id_ctrl with IF_ID_SZ=8, REDIRECT_LAT=2.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after it.
module tb_if_id_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       if_valid1, if_valid2;
  logic       id_accept1, id_accept2;
  logic       flush;
  logic       din1_en, din2_en;
  logic       dout1_req, dout2_req;
  logic       cb_clear, if_id_enable;
  logic [3:0] count;
  logic       out_valid1, out_valid2;
  logic       fetch_stall, full, full_almost;

  int checks   = 0;
  int failures = 0;

  if_id_ctrl #(
    .IF_ID_SZ(8),
    .IF_ID_IDX(3),
    .REDIRECT_LAT(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_valid1(if_valid1),
    .if_valid2(if_valid2),
    .id_accept1(id_accept1),
    .id_accept2(id_accept2),
    .flush(flush),
    .din1_en(din1_en),
    .din2_en(din2_en),
    .dout1_req(dout1_req),
    .dout2_req(dout2_req),
    .cb_clear(cb_clear),
    .if_id_enable(if_id_enable),
    .count(count),
    .out_valid1(out_valid1),
    .out_valid2(out_valid2),
    .fetch_stall(fetch_stall),
    .full(full),
    .full_almost(full_almost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strb(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, din1_en, din2_en, dout1_req, dout2_req}, {28'd0, exp});
  endtask

  task automatic drv(input logic v1, input logic v2, input logic a1,
                     input logic a2, input logic f);
    if_valid1  = v1;
    if_valid2  = v2;
    id_accept1 = a1;
    id_accept2 = a2;
    flush      = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drv(1, 1, 1, 1, 0);
    // reset held for two edges
    tick(); #1;
    chk("rst_count", count, 0);
    strb("rst_strobes", 4'b0000);
    chk("rst_cb_clear", cb_clear, 0);
    tick(); #1;
    chk("rst2_count", count, 0);
    strb("rst2_strobes", 4'b0000);
    // release: one FLUSH cycle
    tick();
    reset = 1'b1;
    #1;
    chk("flush_cb", cb_clear, 1);
    chk("flush_en", if_id_enable, 0);
    strb("flush_strobes", 4'b0000);
    chk("flush_stall", fetch_stall, 1);
    // two WAIT cycles drop fetch
    tick(); #1;
    chk("wait1_cb", cb_clear, 0);
    chk("wait1_en", if_id_enable, 1);
    strb("wait1_strobes", 4'b0000);
    chk("wait1_stall", fetch_stall, 1);
    tick(); #1;
    strb("wait2_strobes", 4'b0000);
    chk("wait2_cb", cb_clear, 0);
    // RUN: fill with both slots, no accept
    tick();
    drv(1, 1, 0, 0, 0);
    #1;
    chk("run_count0", count, 0);
    chk("run_stall", fetch_stall, 0);
    strb("fill1_strobes", 4'b1100);
    tick(); #1;
    chk("fill_c2", count, 2);
    strb("fill2_strobes", 4'b1100);
    tick(); #1;
    chk("fill_c4", count, 4);
    strb("fill3_strobes", 4'b1100);
    tick(); #1;
    chk("fill_c6", count, 6);
    chk("c6_stall", fetch_stall, 0);
    strb("fill4_strobes", 4'b1100);
    tick(); #1;
    chk("fill_c8", count, 8);
    chk("c8_full", full, 1);
    chk("c8_almost", full_almost, 1);
    chk("c8_stall", fetch_stall, 1);
    strb("c8_strobes", 4'b0000);
    // one read to reach 7
    tick();
    drv(0, 0, 1, 0, 0);
    #1;
    strb("rd1_strobes", 4'b0010);
    tick();
    drv(1, 1, 0, 0, 0);
    #1;
    chk("c7_count", count, 7);
    chk("c7_full", full, 0);
    chk("c7_almost", full_almost, 1);
    chk("c7_stall", fetch_stall, 1);
    chk("c7_ov2", out_valid2, 1);
    strb("c7_partial", 4'b1000);
    // simultaneous read and write from full
    tick();
    drv(1, 1, 1, 1, 0);
    #1;
    chk("rw_c8", count, 8);
    strb("rw_full_strobes", 4'b0011);
    tick(); #1;
    chk("rw_c6", count, 6);
    strb("rw_c6_strobes", 4'b1111);
    tick(); #1;
    chk("rw_c6_hold", count, 6);
    // drop to 5
    drv(0, 0, 1, 0, 0);
    #1;
    strb("to5_strobes", 4'b0010);
    tick();
    drv(1, 1, 1, 1, 1);
    #1;
    chk("pre_flush_c5", count, 5);
    strb("flush_cycle_strobes", 4'b0000);
    chk("flush_cycle_cb", cb_clear, 0);
    // FLUSH after mid-stream flush
    tick();
    drv(1, 1, 1, 1, 0);
    #1;
    chk("mf_cb", cb_clear, 1);
    chk("mf_count", count, 0);
    chk("mf_en", if_id_enable, 0);
    chk("mf_ov1", out_valid1, 0);
    strb("mf_strobes", 4'b0000);
    // flush again in first WAIT cycle
    tick(); #1;
    chk("mw_cb", cb_clear, 0);
    strb("mw_strobes", 4'b0000);
    flush = 1'b1;
    #1;
    strb("mw_flush_strobes", 4'b0000);
    tick();
    flush = 1'b0;
    #1;
    chk("re_flush_cb", cb_clear, 1);
    tick(); #1;
    chk("rw1_cb", cb_clear, 0);
    chk("rw1_stall", fetch_stall, 1);
    strb("rw1_strobes", 4'b0000);
    tick(); #1;
    chk("rw2_stall", fetch_stall, 1);
    strb("rw2_strobes", 4'b0000);
    // writes resume, reads see nothing written this cycle
    tick(); #1;
    chk("resume_stall", fetch_stall, 0);
    chk("resume_count", count, 0);
    strb("resume_strobes", 4'b1100);
    tick(); #1;
    chk("resume_c2", count, 2);
    strb("c2_rw_strobes", 4'b1111);
    tick(); #1;
    chk("c2_hold", count, 2);
    chk("c2_ov2", out_valid2, 1);
    // reset mid-WAIT overrides flush
    drv(0, 0, 0, 0, 1);
    tick();
    drv(0, 0, 0, 0, 0);
    tick();
    flush = 1'b1;
    reset = 1'b0;
    #1;
    strb("rst_wait_strobes", 4'b0000);
    tick();
    reset = 1'b1;
    flush = 1'b0;
    #1;
    chk("rst_wait_cb", cb_clear, 1);
    tick(); #1;
    chk("rst_wait_next_cb", cb_clear, 0);
    chk("rst_wait_next_en", if_id_enable, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
